uart_frame_parser: RTL and testbench
====================================

// Module: uart_frame_parser
// PURPOSE
//  Downstream of the UART driver's RX side, in the baud-clock (o_user_clk) domain.
//  Consumes the received byte stream (data + vaild strobe, no backpressure).
//  Parses command frames: 0x55 0xAA | CMD | LEN | PAYLOAD[LEN] | SUM.
//  Streams the payload out as it arrives, then reports frame done or a frame error.
// PARAMETERS
//  P_HEAD0         8'h55  first header byte
//  P_HEAD1         8'hAA  second header byte
//  P_MAX_LEN       16     max payload length accepted (1..255)
//  P_TIMEOUT_CYCLE 200    i_clk cycles allowed between bytes inside a frame
// PORTS
//  i_clk                 in   1  baud-domain clock (driver o_user_clk)
//  i_rst_n               in   1  synchronous reset, active-low
//  i_rx_data             in   8  received byte
//  i_rx_data_vaild       in   1  one-cycle strobe; i_rx_data is valid when high
//  o_frame_cmd           out  8  CMD byte of the current/last frame
//  o_frame_len           out  8  LEN byte of the current/last frame
//  o_frame_data          out  8  payload byte
//  o_frame_data_vaild    out  1  payload strobe
//  o_frame_data_last     out  1  high with the final payload byte
//  o_frame_done          out  1  1-cycle pulse: good frame, checksum OK
//  o_frame_err           out  1  1-cycle pulse: frame aborted
//  o_frame_err_code      out  2  1=checksum, 2=length>P_MAX_LEN, 3=timeout; held until next err
//  o_busy                out  1  high in any state other than IDLE
// BEHAVIOUR
//  - Clock and reset: single clock; i_rst_n low at a posedge -> state IDLE, all outputs 0.
//    This includes a reset mid-frame: the partial frame is dropped with no err pulse.
//  - FSM states: IDLE, HEAD1, CMD, LEN, DATA, CHK. State advances only on i_rx_data_vaild.
//  - IDLE: byte==P_HEAD0 -> HEAD1; any other byte -> stay in IDLE.
//  - HEAD1: byte==P_HEAD1 -> CMD. byte==P_HEAD0 -> stay in HEAD1 (resync). Else -> IDLE.
//    No error is flagged from IDLE or HEAD1.
//  - CMD: latch o_frame_cmd; sum <= byte -> LEN.
//  - LEN: latch o_frame_len; sum <= sum+byte.
//    LEN==0 -> CHK. LEN>P_MAX_LEN -> err code 2, then IDLE. Otherwise -> DATA, cnt <= 0.
//  - DATA: each byte -> o_frame_data, o_frame_data_vaild=1; sum += byte; cnt++.
//    o_frame_data_last=1 when cnt==LEN-1, and the FSM then moves to CHK.
//  - CHK: byte==sum -> o_frame_done; byte!=sum -> err code 1. Either way -> IDLE.
//  - sum is 8-bit, wraps mod 256, and covers CMD+LEN+payload (header excluded).
//  - Latency: every output strobe/pulse is registered, 1 cycle after the input vaild.
//  - done and err are mutually exclusive; at most one pulse per frame.
//  - Back-to-back frames: the byte after SUM is parsed in IDLE with no gap needed.
//  - o_frame_cmd and o_frame_len hold their values until the next CMD or LEN byte.
// CONFIGURATION
//  - UART_FRAME_TIMEOUT_EN defined:
//    - Gap counter runs in states HEAD1..CHK and clears on each vaild.
//    - If it reaches P_TIMEOUT_CYCLE: err code 3, then IDLE.
//    - If vaild arrives on the same cycle as the timeout, the byte wins (no timeout).
//  - UART_FRAME_TIMEOUT_EN undefined: no counter, code 3 is never produced,
//    and the FSM waits indefinitely for the next byte.
// TESTING
//  - Frame 55 AA 10 03 01 02 03 19 -> 3 data strobes 01,02,03 (last on 03),
//    done pulse, cmd=10, len=3.
//  - Same frame with SUM=18 -> data still streamed, err pulse code 1, no done.
//  - 55 AA 20 11 (LEN=17, P_MAX_LEN=16) -> err code 2, no data strobes,
//    next valid frame parsed OK.
//  - 55 55 AA 01 00 01 -> resync in HEAD1, LEN=0 frame, done pulse, no data strobe.
//  - TIMEOUT_EN: 55 AA 10 then 250-cycle gap -> err code 3 at cycle 200, o_busy drops;
//    same without macro -> no err.
//  - Reset pulled low after 55 AA 10 03 01 -> all outputs 0, IDLE;
//    trailing 02 03 19 ignored, no done/err.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Command-frame parser for the UART RX byte stream: 55 AA | CMD | LEN | PAYLOAD | SUM.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser #(
  parameter logic [7:0] P_HEAD0         = 8'h55,
  parameter logic [7:0] P_HEAD1         = 8'hAA,
  parameter int         P_MAX_LEN       = 16,
  parameter int         P_TIMEOUT_CYCLE = 200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_vaild,
  output logic [7:0] o_frame_cmd,
  output logic [7:0] o_frame_len,
  output logic [7:0] o_frame_data,
  output logic       o_frame_data_vaild,
  output logic       o_frame_data_last,
  output logic       o_frame_done,
  output logic       o_frame_err,
  output logic [1:0] o_frame_err_code,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  // Input is a strobe-only stream: a byte is consumed on every cycle
  // i_rx_data_vaild is high; there is no ready, so the parser never stalls.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD1 = 3'd1,
    S_CMD   = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_CHK   = 3'd5
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(P_MAX_LEN);

  state_t     state;
  logic [7:0] sum;
  logic [7:0] cnt;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int GAP_W = $clog2(P_TIMEOUT_CYCLE + 1);
  logic [GAP_W-1:0] gap;
`endif

  assign o_busy      = (state != S_IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state              <= S_IDLE;
      sum                <= 8'd0;
      cnt                <= 8'd0;
      o_frame_cmd        <= 8'd0;
      o_frame_len        <= 8'd0;
      o_frame_data       <= 8'd0;
      o_frame_data_vaild <= 1'b0;
      o_frame_data_last  <= 1'b0;
      o_frame_done       <= 1'b0;
      o_frame_err        <= 1'b0;
      o_frame_err_code   <= 2'd0;
`ifdef UART_FRAME_TIMEOUT_EN
      gap                <= '0;
`endif
    end else begin
      o_frame_data_vaild <= 1'b0;
      o_frame_data_last  <= 1'b0;
      o_frame_done       <= 1'b0;
      o_frame_err        <= 1'b0;
      if (i_rx_data_vaild) begin
`ifdef UART_FRAME_TIMEOUT_EN
        gap <= '0;
`endif
        case (state)
          S_IDLE: begin
            if (i_rx_data == P_HEAD0) state <= S_HEAD1;
          end
          S_HEAD1: begin
            // A repeated first header byte keeps us aligned on the newest 0x55.
            if (i_rx_data == P_HEAD1)      state <= S_CMD;
            else if (i_rx_data != P_HEAD0) state <= S_IDLE;
          end
          S_CMD: begin
            o_frame_cmd <= i_rx_data;
            sum         <= i_rx_data;
            state       <= S_LEN;
          end
          S_LEN: begin
            o_frame_len <= i_rx_data;
            sum         <= sum + i_rx_data;
            cnt         <= 8'd0;
            if (i_rx_data == 8'd0) begin
              state <= S_CHK;
            end else if (i_rx_data > MAX_LEN_B) begin
              o_frame_err      <= 1'b1;
              o_frame_err_code <= 2'd2;
              state            <= S_IDLE;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            o_frame_data       <= i_rx_data;
            o_frame_data_vaild <= 1'b1;
            sum                <= sum + i_rx_data;
            cnt                <= cnt + 8'd1;
            if (cnt == o_frame_len - 8'd1) begin
              o_frame_data_last <= 1'b1;
              state             <= S_CHK;
            end
          end
          S_CHK: begin
            if (i_rx_data == sum) begin
              o_frame_done <= 1'b1;
            end else begin
              o_frame_err      <= 1'b1;
              o_frame_err_code <= 2'd1;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
`ifdef UART_FRAME_TIMEOUT_EN
      // An arriving byte takes priority over an expiring gap counter.
      else if (state != S_IDLE) begin
        if (gap == GAP_W'(P_TIMEOUT_CYCLE - 1)) begin
          o_frame_err      <= 1'b1;
          o_frame_err_code <= 2'd3;
          state            <= S_IDLE;
          gap              <= '0;
        end else begin
          gap <= gap + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus randomized frames
// scored against an expected-event queue built from the frame contents.
module tb_uart_frame_parser;

  localparam int MAXL = 16;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_rx_data = 8'd0;
  logic       i_rx_data_vaild = 1'b0;
  logic [7:0] o_frame_cmd, o_frame_len, o_frame_data;
  logic       o_frame_data_vaild, o_frame_data_last, o_frame_done, o_frame_err, o_busy;
  logic [1:0] o_frame_err_code;
  logic [2:0] o_dbg_state;

  uart_frame_parser #(.P_MAX_LEN(MAXL), .P_TIMEOUT_CYCLE(200)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_rx_data          (i_rx_data),
    .i_rx_data_vaild    (i_rx_data_vaild),
    .o_frame_cmd        (o_frame_cmd),
    .o_frame_len        (o_frame_len),
    .o_frame_data       (o_frame_data),
    .o_frame_data_vaild (o_frame_data_vaild),
    .o_frame_data_last  (o_frame_data_last),
    .o_frame_done       (o_frame_done),
    .o_frame_err        (o_frame_err),
    .o_frame_err_code   (o_frame_err_code),
    .o_busy             (o_busy),
    .o_dbg_state        (o_dbg_state)
  );

  // Clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Scoreboard: event = {kind[1:0], err_code[1:0], last, data[7:0]}
  // kind 1 = data strobe, 2 = done pulse, 3 = err pulse
  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  payload[256];
  logic [1:0]  last_err = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [12:0] got);
    if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(got), 32'd0);
    else check(tag, 32'(got), 32'(exp_q.pop_front()));
  endtask

  always @(negedge i_clk) begin
    if (o_frame_data_vaild) pop_cmp("data", {2'd1, 2'd0, o_frame_data_last, o_frame_data});
    if (o_frame_done)       pop_cmp("done", {2'd2, 11'd0});
    if (o_frame_err)        pop_cmp("err",  {2'd3, o_frame_err_code, 9'd0});
  end

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    i_rx_data       = b;
    i_rx_data_vaild = 1'b1;
    tick();
    i_rx_data_vaild = 1'b0;
    i_rx_data       = 8'($urandom_range(0, 255));
    repeat ($urandom_range(0, max_gap)) tick();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd"},   32'(o_frame_cmd), 32'd0);
    check({tag, "_len"},   32'(o_frame_len), 32'd0);
    check({tag, "_data"},  32'(o_frame_data), 32'd0);
    check({tag, "_dv"},    32'(o_frame_data_vaild), 32'd0);
    check({tag, "_last"},  32'(o_frame_data_last), 32'd0);
    check({tag, "_done"},  32'(o_frame_done), 32'd0);
    check({tag, "_err"},   32'(o_frame_err), 32'd0);
    check({tag, "_code"},  32'(o_frame_err_code), 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
  endtask

  // Sends 55 AA cmd len payload[0..len-1] sum_byte and queues what the frame must produce.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] sum_byte, input int max_gap);
    logic [7:0] good_sum;
    good_sum = cmd + len;
    for (int i = 0; i < int'(len); i++) good_sum = good_sum + payload[i];
    if (int'(len) > MAXL) begin
      exp_q.push_back({2'd3, 2'd2, 9'd0});
      last_err = 2'd2;
    end else begin
      for (int i = 0; i < int'(len); i++)
        exp_q.push_back({2'd1, 2'd0, (i == int'(len) - 1), payload[i]});
      if (sum_byte == good_sum) begin
        exp_q.push_back({2'd2, 11'd0});
      end else begin
        exp_q.push_back({2'd3, 2'd1, 9'd0});
        last_err = 2'd1;
      end
    end
    send_byte(8'h55, max_gap);
    send_byte(8'hAA, max_gap);
    send_byte(cmd, max_gap);
    send_byte(len, max_gap);
    if (int'(len) <= MAXL) begin
      for (int i = 0; i < int'(len); i++) send_byte(payload[i], max_gap);
      send_byte(sum_byte, max_gap);
    end
    tick();
    check("frame_cmd",  32'(o_frame_cmd), 32'(cmd));
    check("frame_len",  32'(o_frame_len), 32'(len));
    check("frame_idle", 32'(o_busy), 32'd0);
    check("err_code_held", 32'(o_frame_err_code), 32'(last_err));
  endtask

  initial begin
    int n;
    logic [7:0] len, cmd, sum, b;

    // Reset
    repeat (3) tick();
    check_reset_state("reset");
    i_rst_n = 1'b1;
    tick();

    // Known good frame and its corrupted-checksum twin
    payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03;
    send_frame(8'h10, 8'h03, 8'h19, 0);
    send_frame(8'h10, 8'h03, 8'h18, 2);

    // Over-length then a valid frame
    send_frame(8'h20, 8'h11, 8'h00, 0);
    send_frame(8'h10, 8'h03, 8'h19, 1);

    // Header resync followed by an empty-payload frame
    send_byte(8'h55, 0);
    send_frame(8'h01, 8'h00, 8'h01, 0);

    // Long silence inside a frame
`ifdef UART_FRAME_TIMEOUT_EN
    exp_q.push_back({2'd3, 2'd3, 9'd0});
`endif
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h10, 0);
`ifdef UART_FRAME_TIMEOUT_EN
    n = 0;
    while (!o_frame_err && n < 400) begin
      tick();
      n++;
    end
    check("timeout_cycle", 32'(n), 32'd200);
    last_err = 2'd3;
    repeat (50) tick();
    check("timeout_busy", 32'(o_busy), 32'd0);
    check("timeout_code", 32'(o_frame_err_code), 32'd3);
`else
    repeat (250) tick();
    check("no_timeout_busy", 32'(o_busy), 32'd1);
    check("no_timeout_code", 32'(o_frame_err_code), 32'(last_err));
    exp_q.push_back({2'd2, 11'd0});
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    tick();
    check("resume_idle", 32'(o_busy), 32'd0);
    check("resume_len", 32'(o_frame_len), 32'd0);
`endif

    // Reset in the middle of a frame drops it silently
    exp_q.push_back({2'd1, 2'd0, 1'b0, 8'h01});
    send_byte(8'h55, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h10, 0);
    send_byte(8'h03, 0);
    send_byte(8'h01, 0);
    i_rst_n = 1'b0;
    tick();
    check_reset_state("midreset");
    i_rst_n = 1'b1;
    last_err = 2'd0;
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h19, 0);
    tick();
    check("post_reset_busy", 32'(o_busy), 32'd0);
    check("post_reset_code", 32'(o_frame_err_code), 32'd0);

    // Randomized frames with garbage between them
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h55) b = 8'h00;
        send_byte(b, 1);
      end
      cmd = 8'($urandom_range(0, 255));
      n = $urandom_range(0, 9);
      if (n >= 8) len = 8'($urandom_range(MAXL + 1, 255));
      else len = 8'($urandom_range(0, MAXL));
      for (int i = 0; i < int'(len); i++) payload[i] = 8'($urandom_range(0, 255));
      sum = cmd + len;
      for (int i = 0; i < int'(len); i++) sum = sum + payload[i];
      if (n == 6 || n == 7) sum = sum ^ 8'($urandom_range(1, 255));
      send_frame(cmd, len, sum, 3);
    end

    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
